cnn_frame_streamer: RTL and testbench
=====================================

# cnn_frame_streamer

Parametrised successor to the single-pixel CNN control path. It accepts packed multi-pixel words from the AXI-Lite register side and buffers them in a FIFO. It unpacks the words into a one-pixel-per-cycle stream for `CNN_TOP`, and sequences a whole frame: start, stream, wait for result, count. Sticky error flags and a maskable completion interrupt are added. It sits between the AXI-Lite slave registers and `CNN_TOP`.

## Interface
- `DATA_WIDTH`, 32: write word width; must be a multiple of `PIXEL_WIDTH`.
- `PIXEL_WIDTH`, 8: pixel width; `PPW = DATA_WIDTH/PIXEL_WIDTH` pixels per word.
- `FRAME_PIXELS`, 1024: pixels per frame; must be a multiple of `PPW`.
- `FIFO_DEPTH`, 16: word FIFO depth; must be a power of 2.
- `TIMEOUT_CYCLES`, 65535: maximum wait for `cnn_result_valid`.

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ctrl_start` in 1: frame start pulse.
- `ctrl_abort` in 1: abort pulse.
- `irq_en` in 1: interrupt enable level.
- `irq_clear` in 1: clears `irq` and `error_code`.
- `wr_valid` in 1: packed word write strobe.
- `wr_data` in `DATA_WIDTH`: packed pixels; the lowest pixel is first.
- `wr_ready` out 1: FIFO not full.
- `pix_valid` out 1: pixel strobe to `CNN_TOP`.
- `pix_data` out `PIXEL_WIDTH`: pixel to `CNN_TOP`.
- `cnn_start` out 1: one-cycle start pulse to `CNN_TOP`.
- `cnn_reset` out 1: one-cycle reset pulse to `CNN_TOP`.
- `cnn_busy` in 1: core busy.
- `cnn_result_valid` in 1: core result ready.
- `frame_active` out 1: state is START, STREAM or WAIT.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `irq` out 1: sticky interrupt.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: number of words held.
- `frame_count` out 32: number of completed frames.
- `error_code` out 4: sticky bits — [0] overflow, [1] start while not IDLE or `cnn_busy`, [2] timeout, [3] abort.

## Operation
- **States:** IDLE, START, STREAM, WAIT.
- **FIFO writes:**
  - A word is written when `wr_valid` is high and the FIFO is not full, in any state.
  - `wr_valid` while full drops the word and sets `error_code[0]`.
- **IDLE:**
  - `ctrl_start` with `cnn_busy=0` → START.
  - `ctrl_start` otherwise is ignored and sets `error_code[1]`.
- **START:** `cnn_start=1` for one cycle; clear the pixel counter and lane index → STREAM.
- **STREAM:**
  - While the FIFO is non-empty, emit lane `k` of the head word (`k = 0..PPW-1`) with `pix_valid=1`.
  - After lane `PPW-1`, pop the word.
  - An empty FIFO stalls with `pix_valid=0`; this is not an error.
  - When the pixel counter reaches `FRAME_PIXELS` → WAIT and clear the timeout counter.
- **WAIT:**
  - `cnn_result_valid` → IDLE: `frame_count++` (wraps at 2^32), `frame_done=1`, and `irq` is set if `irq_en`.
  - Timeout counter reaching `TIMEOUT_CYCLES` → IDLE, `cnn_reset` pulse, `error_code[2]` set.
- **Abort:**
  - `ctrl_abort` in any state → IDLE, `cnn_reset` pulse, FIFO flushed, counters cleared, `error_code[3]` set.
  - Abort wins over a start, write, result or timeout in the same cycle; a write in that cycle is dropped without setting `error_code[0]`.
- **Interrupt clear:** `irq_clear` clears `irq` and `error_code`; a set event in the same cycle wins.
- **Simultaneous push and pop:** `fifo_level` is unchanged.

## Timing
- **Reset values:** all outputs 0 (`wr_ready=1`), state IDLE, FIFO empty.
- **Output registering:** every output is registered except `wr_ready`, which is combinational from `fifo_level`.
- **Start latency:** `ctrl_start` sampled at T gives `cnn_start` at T+1. The first `pix_valid` is at T+2 if the FIFO is non-empty, otherwise one cycle after the first write.
- **Throughput:** 1 pixel per cycle while data is available; `FRAME_PIXELS` cycles minimum in STREAM.
- **Pop timing:** a word is popped in the cycle its last lane is emitted; a word written in that cycle lands behind it.
- **Result latency:** `cnn_result_valid` at cycle R gives `frame_done`, the counter increment and `irq` at R+1.
- **Timeout:** `error_code[2]` and `cnn_reset` appear `TIMEOUT_CYCLES`+1 cycles after entering WAIT.
- **Asynchronous reset mid-frame:** immediate return to reset values; `cnn_reset` is not pulsed.

## Test plan
- Prefill 4 words 0x03020100..0x0F0E0D0C with `FRAME_PIXELS=16`, then `ctrl_start` → `pix_data` 0x00..0x0F on 16 consecutive cycles, `fifo_level` falls 4→0.
- `cnn_result_valid` 5 cycles after the last pixel with `irq_en=1` → `frame_done` one cycle, `frame_count=1`, `irq=1`; `irq_clear` → `irq=0`.
- 17 writes with `FIFO_DEPTH=16` and no start → 16 accepted, `wr_ready=0`, `error_code=4'b0001`.
- Words delivered every 10 cycles → `pix_valid` gaps with no error; frame completes after exactly 1024 pixels.
- No result for `TIMEOUT_CYCLES=100` → `error_code[2]=1`, one `cnn_reset` pulse, state IDLE, `frame_count` unchanged.
- `ctrl_abort` mid-STREAM in the same cycle as `ctrl_start` and `wr_valid` → IDLE, `fifo_level=0`, `error_code=4'b1000`, one `cnn_reset` pulse.

Source files
------------

// File: rtl/cnn_frame_streamer.sv
// Frame streamer between the AXI-Lite registers and CNN_TOP: buffers packed pixel words,
// unpacks them into a pixel-per-cycle stream and sequences a frame with error/irq reporting.
module cnn_frame_streamer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PIXEL_WIDTH    = 8,
    parameter int unsigned FRAME_PIXELS   = 1024,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ctrl_start,
    input  logic                        ctrl_abort,
    input  logic                        irq_en,
    input  logic                        irq_clear,
    input  logic                        wr_valid,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        wr_ready,
    output logic                        pix_valid,
    output logic [PIXEL_WIDTH-1:0]      pix_data,
    output logic                        cnn_start,
    output logic                        cnn_reset,
    input  logic                        cnn_busy,
    input  logic                        cnn_result_valid,
    output logic                        frame_active,
    output logic                        frame_done,
    output logic                        irq,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [31:0]                 frame_count,
    output logic [3:0]                  error_code
);

    localparam int unsigned PPW = DATA_WIDTH / PIXEL_WIDTH;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int unsigned CW  = $clog2(FRAME_PIXELS + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW:0]   LvlFull  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [LW-1:0] LaneLast = LW'(PPW - 1);
    localparam logic [CW-1:0] FrameLen = CW'(FRAME_PIXELS);
    localparam logic [TW-1:0] TmoLimit = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StStart, StStream, StWait} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]             level_q, level_d;
    logic [LW-1:0]           lane_q, lane_d;
    logic [CW-1:0]           pix_cnt_q, pix_cnt_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    pix_valid_q, pix_valid_d;
    logic [PIXEL_WIDTH-1:0]  pix_data_q, pix_data_d;
    logic                    cnn_start_q, cnn_start_d;
    logic                    cnn_reset_q, cnn_reset_d;
    logic                    frame_active_q, frame_active_d;
    logic                    frame_done_q, frame_done_d;
    logic                    irq_q, irq_d;
    logic [31:0]             frame_count_q, frame_count_d;
    logic [3:0]              error_q, error_d;

    logic                    fifo_full;
    logic [DATA_WIDTH-1:0]   head_word;
    logic                    push, pop, done;
    logic [3:0]              err_set;

    assign fifo_full = (level_q == LvlFull);
    assign head_word = mem_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        lane_d        = lane_q;
        pix_cnt_d     = pix_cnt_q;
        tmo_d         = tmo_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        cnn_start_d   = 1'b0;
        cnn_reset_d   = 1'b0;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        err_set       = '0;
        push          = 1'b0;
        pop           = 1'b0;
        done          = 1'b0;

        if (ctrl_abort) begin
            // Abort overrides everything else sampled this cycle, including a write.
            state_d     = StIdle;
            cnn_reset_d = 1'b1;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            lane_d      = '0;
            pix_cnt_d   = '0;
            tmo_d       = '0;
            err_set[3]  = 1'b1;
        end else begin
            push       = wr_valid && !fifo_full;
            err_set[0] = wr_valid && fifo_full;
            err_set[1] = ctrl_start && ((state_q != StIdle) || cnn_busy);

            unique case (state_q)
                StIdle: begin
                    if (ctrl_start && !cnn_busy) begin
                        state_d     = StStart;
                        cnn_start_d = 1'b1;
                        lane_d      = '0;
                        pix_cnt_d   = '0;
                    end
                end
                StStart, StStream: begin
                    // START already emits so the first pixel follows cnn_start directly.
                    state_d = StStream;
                    if (level_q != '0) begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = head_word[32'(lane_q) * PIXEL_WIDTH +: PIXEL_WIDTH];
                        pix_cnt_d   = pix_cnt_q + CW'(1);
                        if (lane_q == LaneLast) begin
                            pop    = 1'b1;
                            lane_d = '0;
                        end else begin
                            lane_d = lane_q + LW'(1);
                        end
                    end
                    if (pix_cnt_d == FrameLen) begin
                        state_d = StWait;
                        tmo_d   = '0;
                    end
                end
                StWait: begin
                    tmo_d = tmo_q + TW'(1);
                    if (cnn_result_valid) begin
                        state_d       = StIdle;
                        done          = 1'b1;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 32'd1;
                    end else if (tmo_q == TmoLimit) begin
                        state_d     = StIdle;
                        cnn_reset_d = 1'b1;
                        err_set[2]  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + (AW + 1)'(1);
                2'b01:   level_d = level_q - (AW + 1)'(1);
                default: level_d = level_q;
            endcase
        end

        // A set event in the same cycle as irq_clear wins.
        irq_d          = (irq_clear ? 1'b0 : irq_q) | (done & irq_en);
        error_d        = (irq_clear ? 4'b0000 : error_q) | err_set;
        frame_active_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            lane_q         <= '0;
            pix_cnt_q      <= '0;
            tmo_q          <= '0;
            pix_valid_q    <= 1'b0;
            pix_data_q     <= '0;
            cnn_start_q    <= 1'b0;
            cnn_reset_q    <= 1'b0;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
            irq_q          <= 1'b0;
            frame_count_q  <= '0;
            error_q        <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            lane_q         <= lane_d;
            pix_cnt_q      <= pix_cnt_d;
            tmo_q          <= tmo_d;
            pix_valid_q    <= pix_valid_d;
            pix_data_q     <= pix_data_d;
            cnn_start_q    <= cnn_start_d;
            cnn_reset_q    <= cnn_reset_d;
            frame_active_q <= frame_active_d;
            frame_done_q   <= frame_done_d;
            irq_q          <= irq_d;
            frame_count_q  <= frame_count_d;
            error_q        <= error_d;
        end
    end

    assign wr_ready     = !fifo_full;
    assign pix_valid    = pix_valid_q;
    assign pix_data     = pix_data_q;
    assign cnn_start    = cnn_start_q;
    assign cnn_reset    = cnn_reset_q;
    assign frame_active = frame_active_q;
    assign frame_done   = frame_done_q;
    assign irq          = irq_q;
    assign fifo_level   = level_q;
    assign frame_count  = frame_count_q;
    assign error_code   = error_q;

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Scoreboard bench for cnn_frame_streamer: written words queue their expected pixels, and a
// monitor pops and compares every pixel the DUT presents; directed tasks check control/errors.
module tb_cnn_frame_streamer;

    localparam int unsigned DW    = 32;
    localparam int unsigned PXW   = 8;
    localparam int unsigned FP    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TO    = 100;
    localparam int unsigned PPW   = DW / PXW;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      ctrl_start = 1'b0;
    logic                      ctrl_abort = 1'b0;
    logic                      irq_en = 1'b0;
    logic                      irq_clear = 1'b0;
    logic                      wr_valid = 1'b0;
    logic [DW-1:0]             wr_data = '0;
    logic                      cnn_busy = 1'b0;
    logic                      cnn_result_valid = 1'b0;
    logic                      wr_ready;
    logic                      pix_valid;
    logic [PXW-1:0]            pix_data;
    logic                      cnn_start;
    logic                      cnn_reset;
    logic                      frame_active;
    logic                      frame_done;
    logic                      irq;
    logic [$clog2(DEPTH):0]    fifo_level;
    logic [31:0]               frame_count;
    logic [3:0]                error_code;

    cnn_frame_streamer #(
        .DATA_WIDTH    (DW),
        .PIXEL_WIDTH   (PXW),
        .FRAME_PIXELS  (FP),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ctrl_start      (ctrl_start),
        .ctrl_abort      (ctrl_abort),
        .irq_en          (irq_en),
        .irq_clear       (irq_clear),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .cnn_start       (cnn_start),
        .cnn_reset       (cnn_reset),
        .cnn_busy        (cnn_busy),
        .cnn_result_valid(cnn_result_valid),
        .frame_active    (frame_active),
        .frame_done      (frame_done),
        .irq             (irq),
        .fifo_level      (fifo_level),
        .frame_count     (frame_count),
        .error_code      (error_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [PXW-1:0] exp_pix [$];
    int pix_seen = 0;
    int n_rst = 0;
    int n_done = 0;
    int cyc = 0;
    int last_pix_cyc = 0;
    int rst_cyc = 0;
    int exp_frames = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every presented pixel must be the oldest outstanding expected pixel.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (pix_valid) begin
                if (exp_pix.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pix_unexpected: got pixel 0x%0h, expected none (cycle %0d)",
                             pix_data, cyc);
                end else begin
                    check("pix_data", pix_data, exp_pix.pop_front());
                end
                pix_seen++;
                last_pix_cyc = cyc;
            end
            if (cnn_reset) begin
                n_rst++;
                rst_cyc = cyc;
            end
            if (frame_done) n_done++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [DW-1:0] d, input bit accept);
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_data  = d;
        if (accept) begin
            for (int i = 0; i < int'(PPW); i++) exp_pix.push_back(d[i*PXW +: PXW]);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 ctrl_start = 1'b1;
        @(posedge clk);
        #1 ctrl_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_result();
        @(posedge clk);
        #1 cnn_result_valid = 1'b1;
        @(posedge clk);
        #1 cnn_result_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 irq_clear = 1'b1;
        @(posedge clk);
        #1 irq_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_pix(input int target, input int budget);
        int n;
        n = 0;
        while (pix_seen < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("pix_wait_in_budget", pix_seen >= target, 1);
    endtask

    task automatic finish_frame(input int rdelay, input bit ien);
        irq_en = ien;
        repeat (rdelay) @(negedge clk);
        pulse_result();
        exp_frames++;
        check("frame_done", frame_done, 1);
        check("frame_count", frame_count, exp_frames);
        check("irq_after_done", irq, ien);
        check("frame_active_after_done", frame_active, 0);
        @(negedge clk);
        check("frame_done_one_cycle", frame_done, 0);
        pulse_clear();
        check("irq_cleared", irq, 0);
    endtask

    task automatic run_frame(input int rdelay, input bit ien);
        int base;
        base = pix_seen;
        pulse_start();
        check("cnn_start", cnn_start, 1);
        wait_pix(base + FP, 300);
        finish_frame(rdelay, ien);
    endtask

    int base;
    int cnt;
    int r0;
    int d0;
    int t0;
    int seen;
    int lp;
    int n;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_wr_ready", wr_ready, 1);
        check("reset_fifo_level", fifo_level, 0);
        check("reset_outputs", {pix_valid, cnn_start, cnn_reset, frame_active, frame_done, irq},
              0);
        check("reset_frame_count", frame_count, 0);
        check("reset_error_code", error_code, 0);

        // Prefilled frame: pixels 0x00..0x0F on consecutive cycles starting T+2.
        for (int i = 0; i < 4; i++) begin
            write_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b1);
        end
        @(negedge clk);
        check("prefill_level", fifo_level, 4);
        pulse_start();
        check("start_pulse", cnn_start, 1);
        check("start_active", frame_active, 1);
        cnt = 0;
        for (int i = 0; i < int'(FP); i++) begin
            @(negedge clk);
            if (pix_valid) cnt++;
        end
        check("stream_consecutive", cnt, FP);
        check("stream_level_drained", fifo_level, 0);
        check("wait_active", frame_active, 1);
        repeat (4) @(negedge clk);
        finish_frame(0, 1'b1);

        // Overflow: 17 writes into a 16-deep FIFO with no frame running.
        for (int i = 0; i < 17; i++) write_word($urandom, i < 16);
        @(negedge clk);
        check("full_wr_ready", wr_ready, 0);
        check("full_level", fifo_level, DEPTH);
        check("overflow_error", error_code, 4'b0001);
        pulse_clear();
        check("overflow_cleared", error_code, 0);
        for (int f = 0; f < 4; f++) run_frame($urandom_range(0, 20), 1'($urandom_range(0, 1)));
        check("drain_level", fifo_level, 0);

        // Start while the core is busy is ignored and flagged.
        cnn_busy = 1'b1;
        pulse_start();
        check("busy_no_start", cnn_start, 0);
        check("busy_idle", frame_active, 0);
        check("busy_error", error_code, 4'b0010);
        cnn_busy = 1'b0;
        pulse_clear();

        // Trickled words: stalls without error, frame still ends after FP pixels.
        base = pix_seen;
        t0 = cyc;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            repeat (10) @(posedge clk);
            write_word($urandom, 1'b1);
        end
        wait_pix(base + FP, 300);
        check("trickle_gaps", (last_pix_cyc - t0) > int'(FP) + 2, 1);
        check("trickle_no_error", error_code, 0);
        finish_frame(2, 1'b0);
        check("trickle_pixel_count", pix_seen - base, FP);

        // Randomised frames with a concurrent writer, kept short of full.
        base = pix_seen;
        check("random_level_start", fifo_level, 0);
        fork
            begin
                for (int w = 0; w < 5 * int'(PPW); w++) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    n = 0;
                    while ((w - (pix_seen - base) / int'(PPW)) >= int'(DEPTH) - 2 && n < 500) begin
                        @(negedge clk);
                        n++;
                    end
                    write_word($urandom, 1'b1);
                end
            end
            begin
                for (int f = 0; f < 5; f++) begin
                    run_frame($urandom_range(0, 20), 1'($urandom_range(0, 1)));
                end
            end
        join
        check("random_no_error", error_code, 0);

        // Timeout: no result ever arrives.
        for (int i = 0; i < 4; i++) write_word($urandom, 1'b1);
        base = pix_seen;
        d0 = n_done;
        pulse_start();
        wait_pix(base + FP, 300);
        lp = last_pix_cyc;
        check("timeout_waiting", frame_active, 1);
        r0 = n_rst;
        n = 0;
        while (n_rst == r0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("timeout_latency", rst_cyc - lp, TO + 1);
        repeat (5) @(negedge clk);
        check("timeout_one_reset", n_rst - r0, 1);
        check("timeout_error", error_code, 4'b0100);
        check("timeout_idle", frame_active, 0);
        check("timeout_count_kept", frame_count, exp_frames);
        check("timeout_no_done", n_done - d0, 0);
        pulse_clear();

        // Abort mid-stream together with start and a write.
        for (int i = 0; i < 4; i++) write_word($urandom, 1'b1);
        base = pix_seen;
        pulse_start();
        wait_pix(base + 5, 100);
        r0 = n_rst;
        @(posedge clk);
        #1;
        ctrl_abort = 1'b1;
        ctrl_start = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = $urandom;
        @(posedge clk);
        #1;
        ctrl_abort = 1'b0;
        ctrl_start = 1'b0;
        wr_valid   = 1'b0;
        @(negedge clk);
        exp_pix.delete();
        seen = pix_seen;
        check("abort_level", fifo_level, 0);
        check("abort_error", error_code, 4'b1000);
        check("abort_idle", frame_active, 0);
        check("abort_no_pixel", pix_valid, 0);
        repeat (6) @(negedge clk);
        check("abort_one_reset", n_rst - r0, 1);
        check("abort_stream_stopped", pix_seen, seen);
        pulse_clear();
        check("abort_error_cleared", error_code, 0);

        // Fresh frame after abort must carry only newly written words.
        for (int i = 0; i < 4; i++) write_word($urandom, 1'b1);
        run_frame(3, 1'b1);

        check("scoreboard_empty", exp_pix.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
